store_commit_unit: RTL and testbench
====================================

Name: store_commit_unit

Overview:
- Responder side of the ROB store-commit handshake (commit_store_valid / commit_store_ready / commit_store_ex).
- Buffers executed stores in program order.
- When the ROB head store is ready to retire, the block translates the address through the TLB and writes the data cache.
- Returns a one-cycle ready pulse with any commit-time exception (TLB refill, invalid or modify). Sits between the memory execute pipe, the TLB and the D-cache.

Parameters:
- STQ_DEPTH, 4, number of store-queue entries (power of 2, ≥2).
- ADDR_W, 32, virtual/physical address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush from the commit stage; discards uncommitted stores
- exe_store_valid  in  1  executed store enqueue strobe (program order)
- exe_store_vaddr  in  32  store virtual address (word-aligned, alignment checked upstream)
- exe_store_wdata  in  32  store data, lane-aligned
- exe_store_wstrb  in  4  byte enables
- stq_full  out  1  queue full; execute must stall
- commit_store_valid  in  1  ROB head (or head+1) is in Store_Wait
- commit_store_ready  out  1  one-cycle pulse: head store retired, exception fields valid
- commit_store_ex_ex  out  1  exception flag
- commit_store_ex_exccode  out  5  exccode: 1 = Mod, 3 = TLBS
- commit_store_ex_badvaddr  out  32  faulting vaddr
- commit_store_ex_tlb_refill  out  1  1 on TLB miss (refill vector)
- tlb_req_valid  out  1  translation request
- tlb_req_vaddr  out  32  vaddr to translate
- tlb_resp_paddr  in  32  physical address, valid the cycle after the request
- tlb_resp_miss  in  1  no matching entry
- tlb_resp_invalid  in  1  V bit clear
- tlb_resp_dirty  in  1  D bit (0 → Mod exception)
- dc_req_valid  out  1  D-cache write request
- dc_req_ready  in  1  D-cache accepts request
- dc_req_paddr  out  32  physical address
- dc_req_wdata  out  32  write data
- dc_req_wstrb  out  4  byte enables
- dc_wr_ack  in  1  write complete (≥1 cycle after acceptance)

Behaviour:
- Queue
  - Circular FIFO with head/tail pointers of log2(STQ_DEPTH) bits plus a count of log2(STQ_DEPTH)+1 bits.
  - Enqueue when exe_store_valid && !stq_full.
  - stq_full = (count == STQ_DEPTH).
  - Enqueue while full is dropped.
- FSM states: IDLE, XLATE, MEM_REQ, MEM_WAIT, RESP.
- IDLE → XLATE when commit_store_valid && count != 0.
  - The head entry is latched into a commit register and popped from the queue in the same cycle.
  - tlb_req_valid = 1 in this cycle, with tlb_req_vaddr = head vaddr.
- XLATE: sample the TLB response.
  - tlb_resp_miss → ex=1, exccode=3, tlb_refill=1; → RESP.
  - tlb_resp_invalid → ex=1, exccode=3, tlb_refill=0; → RESP.
  - !tlb_resp_dirty → ex=1, exccode=1; → RESP.
  - Otherwise latch paddr → MEM_REQ.
  - Priority: miss > invalid > dirty. badvaddr = vaddr on any exception.
- MEM_REQ: dc_req_valid = 1 with address, data and strobes held stable until dc_req_ready; on handshake → MEM_WAIT.
- MEM_WAIT: on dc_wr_ack → RESP.
- RESP: commit_store_ready = 1 for exactly one cycle with the latched exception fields; → IDLE. The ex fields are 0 when no exception.
- Latency: minimum 4 cycles from accept to ready on the success path (IDLE, XLATE, MEM_REQ with ready=1, MEM_WAIT with ack=1, RESP asserted in the 5th cycle); exception path asserts ready 2 cycles after accept.
- One store in flight at a time. commit_store_valid is ignored outside IDLE and in the cycle after RESP.
  - A 1-cycle re-arm guard is required because the ROB clears Store_Wait one edge after the ready pulse.
- Flush
  - Clears all queue entries, head, tail and count in the same cycle; an enqueue in the flush cycle is dropped.
  - In XLATE or RESP: return to IDLE, no ready pulse, no memory write.
  - In MEM_REQ or MEM_WAIT: the write has been committed architecturally, so it must complete. The FSM continues to drain through ack but suppresses the ready pulse (RESP is skipped, go to IDLE).
  - A flush during drain does not re-enter IDLE early; stq_full stays 0 during drain.
- Simultaneous enqueue and pop in IDLE: count unchanged.
- Pointer wrap-around is modulo STQ_DEPTH.
- Reset (also mid-operation)
  - FSM to IDLE, queue empty, all outputs 0.
  - stq_full=0, commit_store_ready=0, tlb_req_valid=0, dc_req_valid=0.
  - Any in-flight D-cache request is abandoned.
- All outputs not listed as driven in a state are 0.

Test Plan:
- Enqueue one store (vaddr 0x8000_0010, wdata 0xDEADBEEF, wstrb 4'hF); assert commit_store_valid; TLB returns paddr 0x0000_0010, dirty=1; dc_req_ready=1, ack next cycle → dc write to 0x10 with 0xDEADBEEF, single ready pulse with ex=0, 4 cycles after accept.
- TLB miss on vaddr 0x0040_1000 → no dc_req_valid; ready pulse 2 cycles after accept with ex=1, exccode=3, tlb_refill=1, badvaddr=0x0040_1000.
- dirty=0 with valid mapping → ex=1, exccode=1, tlb_refill=0; then second queued store commits normally.
- Fill 4 stores → stq_full=1 and a 5th enqueue is dropped; commit all 4 back-to-back → writes occur in enqueue order, pointers wrap, count returns to 0.
- Flush in MEM_WAIT with 2 queued stores → ack still consumed, no ready pulse, queue empty afterwards, next commit_store_valid ignored until a new enqueue.
- dc_req_ready held low for 5 cycles → dc_req_* stable throughout; reset asserted in the 3rd cycle → all outputs 0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/store_commit_unit.sv
// rtl/store_commit_unit.sv - in-order store queue that translates and writes the ROB head store at commit
// Answers the ROB commit handshake with a one-cycle ready pulse carrying any TLB exception.
module store_commit_unit #(
  parameter int STQ_DEPTH = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              exe_store_valid,
  input  logic [ADDR_W-1:0] exe_store_vaddr,
  input  logic [31:0]       exe_store_wdata,
  input  logic [3:0]        exe_store_wstrb,
  output logic              stq_full,
  input  logic              commit_store_valid,
  output logic              commit_store_ready,
  output logic              commit_store_ex_ex,
  output logic [4:0]        commit_store_ex_exccode,
  output logic [ADDR_W-1:0] commit_store_ex_badvaddr,
  output logic              commit_store_ex_tlb_refill,
  output logic              tlb_req_valid,
  output logic [ADDR_W-1:0] tlb_req_vaddr,
  input  logic [ADDR_W-1:0] tlb_resp_paddr,
  input  logic              tlb_resp_miss,
  input  logic              tlb_resp_invalid,
  input  logic              tlb_resp_dirty,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic [ADDR_W-1:0] dc_req_paddr,
  output logic [31:0]       dc_req_wdata,
  output logic [3:0]        dc_req_wstrb,
  input  logic              dc_wr_ack
);

  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XLATE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] stq_vaddr_q [STQ_DEPTH];
  logic [31:0]       stq_wdata_q [STQ_DEPTH];
  logic [3:0]        stq_wstrb_q [STQ_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic [ADDR_W-1:0] cm_vaddr_q, cm_paddr_q, badvaddr_q;
  logic [31:0]       cm_wdata_q;
  logic [3:0]        cm_wstrb_q;
  logic              ex_q, refill_q;
  logic [4:0]        exccode_q;
  logic              drop_q;
  logic              guard_q;

  logic enq, accept, xlate_ex;

  assign stq_full = (count_q == CNT_W'(STQ_DEPTH));
  assign enq      = exe_store_valid && !stq_full && !flush;
  // guard_q masks the cycle after RESP, while the ROB still shows Store_Wait
  assign accept   = (state_q == S_IDLE) && commit_store_valid && (count_q != '0)
                    && !guard_q && !flush;
  assign xlate_ex = tlb_resp_miss || tlb_resp_invalid || !tlb_resp_dirty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < STQ_DEPTH; i++) begin
        stq_vaddr_q[i] <= '0;
        stq_wdata_q[i] <= '0;
        stq_wstrb_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        stq_vaddr_q[tail_q] <= exe_store_vaddr;
        stq_wdata_q[tail_q] <= exe_store_wdata;
        stq_wstrb_q[tail_q] <= exe_store_wstrb;
        tail_q              <= tail_q + 1'b1;
      end
      if (accept) head_q <= head_q + 1'b1;
      case ({enq, accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cm_vaddr_q <= '0;
      cm_wdata_q <= '0;
      cm_wstrb_q <= '0;
      cm_paddr_q <= '0;
      ex_q       <= 1'b0;
      exccode_q  <= '0;
      refill_q   <= 1'b0;
      badvaddr_q <= '0;
      drop_q     <= 1'b0;
      guard_q    <= 1'b0;
    end else begin
      guard_q <= (state_q == S_RESP);
      if (accept) begin
        cm_vaddr_q <= stq_vaddr_q[head_q];
        cm_wdata_q <= stq_wdata_q[head_q];
        cm_wstrb_q <= stq_wstrb_q[head_q];
        drop_q     <= 1'b0;
      end
      if (state_q == S_XLATE) begin
        ex_q       <= xlate_ex;
        refill_q   <= tlb_resp_miss;
        badvaddr_q <= xlate_ex ? cm_vaddr_q : '0;
        if (tlb_resp_miss || tlb_resp_invalid) exccode_q <= EXC_TLBS;
        else if (!tlb_resp_dirty)              exccode_q <= EXC_MOD;
        else                                   exccode_q <= '0;
        if (!xlate_ex) cm_paddr_q <= tlb_resp_paddr;
      end
      // the write is already architectural: finish it, but owe the ROB no pulse
      if ((state_q == S_MEM_REQ || state_q == S_MEM_WAIT) && flush) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = S_XLATE;
      S_XLATE: begin
        if (flush)         state_d = S_IDLE;
        else if (xlate_ex) state_d = S_RESP;
        else               state_d = S_MEM_REQ;
      end
      S_MEM_REQ:  if (dc_req_ready) state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (dc_wr_ack) state_d = (drop_q || flush) ? S_IDLE : S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tlb_req_valid              = 1'b0;
    tlb_req_vaddr              = '0;
    dc_req_valid               = 1'b0;
    dc_req_paddr               = '0;
    dc_req_wdata               = '0;
    dc_req_wstrb               = '0;
    commit_store_ready         = 1'b0;
    commit_store_ex_ex         = 1'b0;
    commit_store_ex_exccode    = '0;
    commit_store_ex_badvaddr   = '0;
    commit_store_ex_tlb_refill = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tlb_req_valid = 1'b1;
          tlb_req_vaddr = stq_vaddr_q[head_q];
        end
      end
      S_MEM_REQ: begin
        dc_req_valid = 1'b1;
        dc_req_paddr = cm_paddr_q;
        dc_req_wdata = cm_wdata_q;
        dc_req_wstrb = cm_wstrb_q;
      end
      S_RESP: begin
        if (!flush) begin
          commit_store_ready         = 1'b1;
          commit_store_ex_ex         = ex_q;
          commit_store_ex_exccode    = exccode_q;
          commit_store_ex_badvaddr   = badvaddr_q;
          commit_store_ex_tlb_refill = refill_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_commit_unit.sv
// tb/tb_store_commit_unit.sv - scoreboard bench for store_commit_unit
// Expected writes and responses are queued at commit time and popped by a negedge monitor.
module tb_store_commit_unit;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        exe_store_valid;
  logic [31:0] exe_store_vaddr, exe_store_wdata;
  logic [3:0]  exe_store_wstrb;
  logic        stq_full;
  logic        commit_store_valid, commit_store_ready;
  logic        commit_store_ex_ex, commit_store_ex_tlb_refill;
  logic [4:0]  commit_store_ex_exccode;
  logic [31:0] commit_store_ex_badvaddr;
  logic        tlb_req_valid;
  logic [31:0] tlb_req_vaddr, tlb_resp_paddr;
  logic        tlb_resp_miss, tlb_resp_invalid, tlb_resp_dirty;
  logic        dc_req_valid, dc_req_ready, dc_wr_ack;
  logic [31:0] dc_req_paddr, dc_req_wdata;
  logic [3:0]  dc_req_wstrb;

  always #5 clk = ~clk;

  store_commit_unit dut (
    .clk(clk), .reset(reset), .flush(flush),
    .exe_store_valid(exe_store_valid), .exe_store_vaddr(exe_store_vaddr),
    .exe_store_wdata(exe_store_wdata), .exe_store_wstrb(exe_store_wstrb),
    .stq_full(stq_full),
    .commit_store_valid(commit_store_valid), .commit_store_ready(commit_store_ready),
    .commit_store_ex_ex(commit_store_ex_ex), .commit_store_ex_exccode(commit_store_ex_exccode),
    .commit_store_ex_badvaddr(commit_store_ex_badvaddr),
    .commit_store_ex_tlb_refill(commit_store_ex_tlb_refill),
    .tlb_req_valid(tlb_req_valid), .tlb_req_vaddr(tlb_req_vaddr),
    .tlb_resp_paddr(tlb_resp_paddr), .tlb_resp_miss(tlb_resp_miss),
    .tlb_resp_invalid(tlb_resp_invalid), .tlb_resp_dirty(tlb_resp_dirty),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_paddr(dc_req_paddr), .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
    .dc_wr_ack(dc_wr_ack)
  );

  typedef struct { logic [31:0] vaddr; logic [31:0] wdata; logic [3:0] wstrb; } store_t;
  typedef struct { logic ex; logic [4:0] code; logic [31:0] bad; logic refill; } resp_t;
  typedef struct { logic [31:0] paddr; logic [31:0] wdata; logic [3:0] wstrb; } wr_t;

  store_t model_q[$];
  resp_t  exp_resp[$];
  wr_t    exp_wr[$];
  int     rdy_cyc[$];
  int     checks = 0, failures = 0, cyc = 0;
  logic   main_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // TLB: identity mapping minus the segment bits, flags from bench config
  logic [31:0] tlb_va_q = '0;
  logic cfg_miss, cfg_inv, cfg_dirty;
  always @(posedge clk) if (tlb_req_valid) tlb_va_q <= tlb_req_vaddr;
  assign tlb_resp_paddr   = tlb_va_q & 32'h1FFF_FFFF;
  assign tlb_resp_miss    = cfg_miss;
  assign tlb_resp_invalid = cfg_inv;
  assign tlb_resp_dirty   = cfg_dirty;

  // D-cache: ack arrives ack_delay cycles after the accepting edge
  logic dc_ready_cfg;
  int   ack_delay, ack_cnt = 0;
  assign dc_req_ready = dc_ready_cfg;
  assign dc_wr_ack    = (ack_cnt == 1);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset)                             ack_cnt <= 0;
    else if (dc_req_valid && dc_req_ready) ack_cnt <= ack_delay;
    else if (ack_cnt != 0)                 ack_cnt <= ack_cnt - 1;
  end

  wr_t   mon_w;
  resp_t mon_r;
  always @(negedge clk) begin
    if (!reset && dc_req_valid && dc_req_ready) begin
      if (exp_wr.size() == 0) check_eq("unexp_dc_write", dc_req_valid, 1'b0);
      else begin
        mon_w = exp_wr.pop_front();
        check_eq("dc_paddr", dc_req_paddr, mon_w.paddr);
        check_eq("dc_wdata", dc_req_wdata, mon_w.wdata);
        check_eq("dc_wstrb", dc_req_wstrb, mon_w.wstrb);
      end
    end
    if (!reset && commit_store_ready) begin
      rdy_cyc.push_back(cyc);
      if (exp_resp.size() == 0) check_eq("unexp_ready", commit_store_ready, 1'b0);
      else begin
        mon_r = exp_resp.pop_front();
        check_eq("ex_ex", commit_store_ex_ex, mon_r.ex);
        check_eq("ex_code", commit_store_ex_exccode, mon_r.code);
        check_eq("ex_bad", commit_store_ex_badvaddr, mon_r.bad);
        check_eq("ex_refill", commit_store_ex_tlb_refill, mon_r.refill);
      end
    end
  end

  task automatic enq(input logic [31:0] va, input logic [31:0] wd, input logic [3:0] ws,
                     input bit to_model);
    store_t s;
    @(posedge clk); #1;
    exe_store_valid = 1'b1; exe_store_vaddr = va; exe_store_wdata = wd; exe_store_wstrb = ws;
    s.vaddr = va; s.wdata = wd; s.wstrb = ws;
    if (to_model) model_q.push_back(s);
    @(posedge clk); #1;
    exe_store_valid = 1'b0;
  endtask

  // Pops the model head and queues the outcome the current TLB config implies
  task automatic expect_head(output store_t s);
    resp_t r;
    wr_t   w;
    s = model_q.pop_front();
    r.ex = 1'b1; r.bad = s.vaddr; r.refill = 1'b0; r.code = 5'd3;
    if (cfg_miss)        r.refill = 1'b1;
    else if (cfg_inv)    r.code = 5'd3;
    else if (!cfg_dirty) r.code = 5'd1;
    else begin
      r.ex = 1'b0; r.bad = '0; r.code = '0;
      w.paddr = s.vaddr & 32'h1FFF_FFFF; w.wdata = s.wdata; w.wstrb = s.wstrb;
      exp_wr.push_back(w);
    end
    exp_resp.push_back(r);
  endtask

  task automatic commit_one(input string tag, input int exp_lat);
    store_t s;
    int n;
    expect_head(s);
    @(posedge clk); #1;
    commit_store_valid = 1'b1;
    @(negedge clk);
    check_eq({tag, "_tlb_valid"}, tlb_req_valid, 1'b1);
    check_eq({tag, "_tlb_vaddr"}, tlb_req_vaddr, s.vaddr);
    @(posedge clk); #1;
    commit_store_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (commit_store_ready) break;
    end
    check_eq({tag, "_latency"}, n, exp_lat);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    check_eq("watchdog_done", main_done, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    store_t s;
    int n, base;
    reset = 1'b1; flush = 1'b0; exe_store_valid = 1'b0; exe_store_vaddr = '0;
    exe_store_wdata = '0; exe_store_wstrb = '0; commit_store_valid = 1'b0;
    cfg_miss = 1'b0; cfg_inv = 1'b0; cfg_dirty = 1'b1; dc_ready_cfg = 1'b1; ack_delay = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_full", stq_full, 1'b0);
    check_eq("rst_ready", commit_store_ready, 1'b0);
    check_eq("rst_tlb", tlb_req_valid, 1'b0);
    check_eq("rst_dc", dc_req_valid, 1'b0);

    enq(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1);
    commit_one("ok", 4);

    cfg_miss = 1'b1;
    enq(32'h0040_1000, 32'h1234_5678, 4'h3, 1);
    commit_one("miss", 2);
    cfg_miss = 1'b0;

    cfg_inv = 1'b1;
    enq(32'h0040_2000, 32'h0BAD_F00D, 4'hC, 1);
    commit_one("inv", 2);
    cfg_inv = 1'b0;

    cfg_miss = 1'b1; cfg_inv = 1'b1; cfg_dirty = 1'b0;
    enq(32'h0040_3000, 32'h0000_0001, 4'h1, 1);
    commit_one("prio", 2);
    cfg_miss = 1'b0; cfg_inv = 1'b0;

    enq(32'h0050_0000, 32'hAAAA_0001, 4'hF, 1);
    enq(32'h8050_0004, 32'hAAAA_0002, 4'h8, 1);
    commit_one("mod", 2);
    cfg_dirty = 1'b1;
    commit_one("after_mod", 4);

    for (int i = 0; i < 4; i++)
      enq(32'h8000_1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'(1 << i), 1);
    @(negedge clk);
    check_eq("full_set", stq_full, 1'b1);
    enq(32'h8000_2000, 32'hFFFF_FFFF, 4'hF, 0);
    @(negedge clk);
    check_eq("full_hold", stq_full, 1'b1);
    base = rdy_cyc.size();
    for (int i = 0; i < 4; i++) expect_head(s);
    @(posedge clk); #1;
    commit_store_valid = 1'b1;
    n = 0;
    while (rdy_cyc.size() < base + 4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    commit_store_valid = 1'b0;
    check_eq("b2b_count", rdy_cyc.size(), base + 4);
    if (rdy_cyc.size() >= base + 4)
      for (int i = 1; i < 4; i++)
        check_eq("b2b_spacing", rdy_cyc[base + i] - rdy_cyc[base + i - 1], 6);
    check_eq("b2b_full_clr", stq_full, 1'b0);

    ack_delay = 3;
    enq(32'h8000_3000, 32'h5151_0000, 4'hF, 1);
    enq(32'h8000_3004, 32'h5151_0001, 4'hF, 1);
    enq(32'h8000_3008, 32'h5151_0002, 4'hF, 1);
    expect_head(s);
    void'(exp_resp.pop_back());
    @(posedge clk); #1;
    commit_store_valid = 1'b1;
    @(posedge clk); #1;
    commit_store_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (dc_req_valid && dc_req_ready) break;
    end
    check_eq("flush_handshake", dc_req_valid && dc_req_ready, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_q.delete();
    repeat (6) @(negedge clk);
    check_eq("flush_wr_done", exp_wr.size(), 0);
    check_eq("flush_full", stq_full, 1'b0);
    @(posedge clk); #1;
    commit_store_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("flush_empty_tlb", tlb_req_valid, 1'b0);
    end
    @(posedge clk); #1;
    commit_store_valid = 1'b0;
    ack_delay = 1;
    enq(32'h8000_4000, 32'h7777_8888, 4'h5, 1);
    commit_one("post_flush", 4);

    dc_ready_cfg = 1'b0;
    enq(32'h8000_0100, 32'hAAAA_5555, 4'h6, 1);
    s = model_q.pop_front();
    @(posedge clk); #1;
    commit_store_valid = 1'b1;
    @(posedge clk); #1;
    commit_store_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (dc_req_valid) break;
    end
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("stall_valid", dc_req_valid, 1'b1);
      check_eq("stall_paddr", dc_req_paddr, s.vaddr & 32'h1FFF_FFFF);
      check_eq("stall_wdata", dc_req_wdata, s.wdata);
      check_eq("stall_wstrb", dc_req_wstrb, s.wstrb);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst2_dc_valid", dc_req_valid, 1'b0);
    check_eq("rst2_dc_paddr", dc_req_paddr, 32'h0);
    check_eq("rst2_dc_wdata", dc_req_wdata, 32'h0);
    check_eq("rst2_tlb", tlb_req_valid, 1'b0);
    check_eq("rst2_ready", commit_store_ready, 1'b0);
    check_eq("rst2_full", stq_full, 1'b0);
    dc_ready_cfg = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst2_idle", dc_req_valid, 1'b0);
    end
    enq(32'h8000_0200, 32'h1357_9BDF, 4'hF, 1);
    commit_one("post_rst", 4);

    repeat (4) @(negedge clk);
    check_eq("end_resp_empty", exp_resp.size(), 0);
    check_eq("end_wr_empty", exp_wr.size(), 0);
    main_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
